// File: rtl/text_console_writer_if.sv
// ----------------------------------------------------------------------------
// text_console_writer_if
// Character stream from the CPU into the text console writer.
//   char_in     CPU -> writer  character code
//   char_valid  CPU -> writer  char_in holds a character
//   char_ready  writer -> CPU  writer accepts char_in this cycle
//   clear_req   CPU -> writer  request a full-screen clear
// Modports: master = CPU side, slave = console writer side.
// ----------------------------------------------------------------------------
interface text_console_writer_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] char_in;
    logic              char_valid;
    logic              char_ready;
    logic              clear_req;

    modport master (
        output char_in,
        output char_valid,
        output clear_req,
        input  char_ready
    );

    modport slave (
        input  char_in,
        input  char_valid,
        input  clear_req,
        output char_ready
    );
endinterface

// File: rtl/text_console_writer.sv
// ----------------------------------------------------------------------------
// text_console_writer
// Writer side of the VGA text RAM. Takes characters from the CPU over a
// valid/ready stream, writes printable characters into the RAM write port at
// the cursor cell, interprets LF/CR/BS, wraps the cursor at line and screen
// ends, and runs a full-screen blanking sweep after reset or on request.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   cpu        slave modport of text_console_writer_if (char stream, clear_req)
//   DataAdr    out  RAM write address
//   WriteData  out  RAM write data
//   MemWrite   out  RAM write strobe (one write per high cycle)
//   cursor_col out  current column, 0..COLS-1
//   cursor_row out  current row, 0..ROWS-1
//   busy       out  high while writing a character or clearing
//
// Build option: CONSOLE_AUTOCLEAR_EN -- when defined, moving the cursor out of
// the last row blanks the screen before the next character; otherwise the
// cursor returns to row 0 and old contents are overwritten in place.
// ----------------------------------------------------------------------------
module text_console_writer #(
    parameter int unsigned       COLS       = 11,
    parameter int unsigned       ROWS       = 11,
    parameter int unsigned       ADDR_W     = 11,
    parameter int unsigned       DATA_W     = 8,
    parameter int unsigned       BASE_ADDR  = 0,
    parameter logic [DATA_W-1:0] BLANK_CHAR = DATA_W'(8'h20)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    text_console_writer_if.slave  cpu,
    output logic [ADDR_W-1:0]     DataAdr,
    output logic [DATA_W-1:0]     WriteData,
    output logic                  MemWrite,
    output logic [3:0]            cursor_col,
    output logic [3:0]            cursor_row,
    output logic                  busy
);

    localparam int unsigned       N_CELLS  = COLS * ROWS;
    localparam int unsigned       CNT_W    = $clog2(N_CELLS + 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(COLS);
    localparam logic [3:0]        LAST_COL = 4'(COLS - 1);
    localparam logic [3:0]        LAST_ROW = 4'(ROWS - 1);
    localparam logic [CNT_W-1:0]  CLR_DONE = CNT_W'(N_CELLS);
    localparam logic [DATA_W-1:0] CH_LF    = DATA_W'(8'h0A);
    localparam logic [DATA_W-1:0] CH_CR    = DATA_W'(8'h0D);
    localparam logic [DATA_W-1:0] CH_BS    = DATA_W'(8'h08);

    if (64'(BASE_ADDR) + 64'(COLS) * 64'(ROWS) > (64'd1 << ADDR_W)) begin : g_addr_range_err
        $error("text_console_writer: screen does not fit in the RAM address space");
    end

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_WRITE
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    clr_cnt_q;
    logic [3:0]          col_q,      col_d;
    logic [3:0]          row_q,      row_d;
    logic [ADDR_W-1:0]   row_base_q, row_base_d;
    logic [ADDR_W-1:0]   addr_q,     waddr_d;
    logic [DATA_W-1:0]   wdata_q,    wdata_d;
    logic                we_q,       we_d;
    logic                ready_q;
    logic                busy_q;
    logic                newline_d;
    logic [ADDR_W-1:0]   cell_addr;
`ifdef CONSOLE_AUTOCLEAR_EN
    logic                wrap_q,     wrap_d;
`endif

    // row_base tracks row*COLS incrementally so no multiplier is needed
    assign cell_addr = BASE + row_base_q + ADDR_W'(col_q);

    // Effect of the character currently on char_in, applied on acceptance
    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        newline_d  = 1'b0;
        we_d       = 1'b0;
        waddr_d    = cell_addr;
        wdata_d    = cpu.char_in;
`ifdef CONSOLE_AUTOCLEAR_EN
        wrap_d     = 1'b0;
`endif
        case (cpu.char_in)
            CH_LF: begin
                col_d     = '0;
                newline_d = 1'b1;
            end
            CH_CR: col_d = '0;
            CH_BS: begin
                if (col_q != '0) begin
                    col_d   = col_q - 4'd1;
                    we_d    = 1'b1;
                    waddr_d = cell_addr - ADDR_W'(1);
                    wdata_d = BLANK_CHAR;
                end
            end
            default: begin
                we_d = 1'b1;
                if (col_q == LAST_COL) begin
                    col_d     = '0;
                    newline_d = 1'b1;
                end else begin
                    col_d = col_q + 4'd1;
                end
            end
        endcase
        if (newline_d) begin
            if (row_q == LAST_ROW) begin
                row_d      = '0;
                row_base_d = '0;
`ifdef CONSOLE_AUTOCLEAR_EN
                wrap_d     = 1'b1;
`endif
            end else begin
                row_d      = row_q + 4'd1;
                row_base_d = row_base_q + ROW_STEP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_CLEAR;
            clr_cnt_q  <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            addr_q     <= BASE;
            wdata_q    <= BLANK_CHAR;
            we_q       <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
`ifdef CONSOLE_AUTOCLEAR_EN
            wrap_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_CLEAR: begin
                    if (clr_cnt_q == CLR_DONE) begin
                        we_q       <= 1'b0;
                        col_q      <= '0;
                        row_q      <= '0;
                        row_base_q <= '0;
                        ready_q    <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= S_IDLE;
                    end else begin
                        we_q      <= 1'b1;
                        addr_q    <= BASE + ADDR_W'(clr_cnt_q);
                        wdata_q   <= BLANK_CHAR;
                        clr_cnt_q <= clr_cnt_q + CNT_W'(1);
                    end
                end
                S_IDLE: begin
                    if (cpu.clear_req) begin
                        clr_cnt_q <= '0;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= S_CLEAR;
                    end else if (cpu.char_valid) begin
                        we_q       <= we_d;
                        if (we_d) begin
                            addr_q  <= waddr_d;
                            wdata_q <= wdata_d;
                        end
                        col_q      <= col_d;
                        row_q      <= row_d;
                        row_base_q <= row_base_d;
`ifdef CONSOLE_AUTOCLEAR_EN
                        wrap_q     <= wrap_d;
`endif
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    we_q <= 1'b0;
`ifdef CONSOLE_AUTOCLEAR_EN
                    if (wrap_q) begin
                        wrap_q    <= 1'b0;
                        clr_cnt_q <= '0;
                        state_q   <= S_CLEAR;
                    end else begin
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
`else
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
`endif
                end
                default: state_q <= S_CLEAR;
            endcase
        end
    end

    // A pending clear_req withdraws ready in the same cycle so a char
    // offered alongside it is not consumed.
    assign cpu.char_ready = ready_q & ~cpu.clear_req;
    assign DataAdr        = addr_q;
    assign WriteData      = wdata_q;
    assign MemWrite       = we_q;
    assign cursor_col     = col_q;
    assign cursor_row     = row_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_text_console_writer.sv
module tb_text_console_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] DataAdr;
    logic [7:0]  WriteData;
    logic        MemWrite;
    logic [3:0]  cursor_col;
    logic [3:0]  cursor_row;
    logic        busy;

    text_console_writer_if #(.DATA_W(8)) cif ();

    text_console_writer #(
        .COLS      (11),
        .ROWS      (11),
        .ADDR_W    (11),
        .DATA_W    (8),
        .BASE_ADDR (0),
        .BLANK_CHAR(8'h20)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu       (cif),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .cursor_col(cursor_col),
        .cursor_row(cursor_row),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t         wq[$];
    int unsigned errors = 0;
    int unsigned checks = 0;

    // Log of every RAM write, taken on the falling edge
    always @(negedge clk) begin
        if (rst_n && MemWrite) wq.push_back({DataAdr, WriteData});
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int unsigned n = 0;
        while (cif.char_ready !== 1'b1 && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        check_eq(tag, {31'd0, cif.char_ready}, 32'd1);
    endtask

    // Returns at negedge+1 of the cycle after acceptance (the WRITE cycle)
    task automatic send_char(input logic [7:0] c);
        wait_ready("ready_wait");
        cif.char_in    = c;
        cif.char_valid = 1'b1;
        @(posedge clk); #1;
        cif.char_valid = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic check_sweep(input string tag, input int unsigned first);
        int unsigned bad = 0;
        check_eq({tag, "_count"}, wq.size(), first + 121);
        if (wq.size() >= first + 121) begin
            for (int unsigned i = 0; i < 121; i++) begin
                if (wq[first + i].a != 11'(i) || wq[first + i].d != 8'h20) bad++;
            end
        end
        check_eq({tag, "_bad"}, bad, 0);
    endtask

    task automatic pulse_clear();
        wait_ready("ready_before_clear");
        cif.clear_req = 1'b1;
        @(posedge clk); #1;
        cif.clear_req = 1'b0;
    endtask

    task automatic check_write(input string tag, input logic [10:0] a, input logic [7:0] d);
        check_eq({tag, "_we"},   {31'd0, MemWrite}, 32'd1);
        check_eq({tag, "_addr"}, {21'd0, DataAdr},  {21'd0, a});
        check_eq({tag, "_data"}, {24'd0, WriteData}, {24'd0, d});
    endtask

    task automatic check_cursor(input string tag, input logic [3:0] c, input logic [3:0] r);
        check_eq({tag, "_col"}, {28'd0, cursor_col}, {28'd0, c});
        check_eq({tag, "_row"}, {28'd0, cursor_row}, {28'd0, r});
    endtask

    initial begin
        int unsigned n;
        int unsigned bad;
        cif.char_in    = 8'h00;
        cif.char_valid = 1'b0;
        cif.clear_req  = 1'b0;

        // Reset values
        #12;
        check_eq("rst_we",    {31'd0, MemWrite},       32'd0);
        check_eq("rst_addr",  {21'd0, DataAdr},        32'd0);
        check_eq("rst_data",  {24'd0, WriteData},      32'h20);
        check_eq("rst_ready", {31'd0, cif.char_ready}, 32'd0);
        check_eq("rst_busy",  {31'd0, busy},           32'd1);
        check_cursor("rst", 4'd0, 4'd0);

        // Power-on blanking sweep
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        check_eq("por_busy", {31'd0, busy}, 32'd1);
        wait_ready("por_ready");
        check_sweep("por", 0);
        check_eq("por_idle_we",   {31'd0, MemWrite}, 32'd0);
        check_eq("por_idle_busy", {31'd0, busy},     32'd0);
        check_cursor("por", 4'd0, 4'd0);

        // First character
        send_char(8'h41);
        check_write("A", 11'd0, 8'h41);
        check_cursor("A", 4'd1, 4'd0);
        check_eq("A_busy",  {31'd0, busy},           32'd1);
        check_eq("A_ready", {31'd0, cif.char_ready}, 32'd0);
        @(negedge clk); #1;
        check_eq("A_ready_back", {31'd0, cif.char_ready}, 32'd1);
        check_eq("A_we_off",     {31'd0, MemWrite},       32'd0);

        // Column wrap into row 1
        for (int i = 0; i < 10; i++) send_char(8'h61 + 8'(i));
        check_cursor("row0_full", 4'd0, 4'd1);
        send_char(8'h42);
        check_write("B", 11'd11, 8'h42);
        for (int i = 0; i < 4; i++) send_char(8'h30 + 8'(i));
        check_cursor("col5", 4'd5, 4'd1);
        send_char(8'h0A);
        check_eq("LF_we", {31'd0, MemWrite}, 32'd0);
        check_cursor("LF", 4'd0, 4'd2);
        send_char(8'h43);
        check_write("C", 11'd22, 8'h43);
        send_char(8'h0D);
        check_eq("CR_we", {31'd0, MemWrite}, 32'd0);
        check_cursor("CR", 4'd0, 4'd2);
        send_char(8'h08);
        check_eq("BS0_we", {31'd0, MemWrite}, 32'd0);
        check_cursor("BS0", 4'd0, 4'd2);

        // clear_req beats a simultaneous character
        wait_ready("ready_before_race");
        cif.char_in    = 8'h5A;
        cif.char_valid = 1'b1;
        cif.clear_req  = 1'b1;
        #1;
        check_eq("race_ready", {31'd0, cif.char_ready}, 32'd0);
        @(posedge clk); #1;
        cif.char_valid = 1'b0;
        cif.clear_req  = 1'b0;
        wq.delete();
        wait_ready("race_ready_after");
        check_sweep("race", 0);
        check_cursor("race", 4'd0, 4'd0);
        send_char(8'h44);
        check_write("D", 11'd0, 8'h44);

        // Backspace at col 3 of row 0
        send_char(8'h45);
        send_char(8'h46);
        check_cursor("pre_BS", 4'd3, 4'd0);
        send_char(8'h08);
        check_write("BS", 11'd2, 8'h20);
        check_cursor("BS", 4'd2, 4'd0);
        send_char(8'h0D);
        send_char(8'h08);
        check_eq("BS_col0_we", {31'd0, MemWrite}, 32'd0);

        // Fill the screen, then wrap
        pulse_clear();
        wait_ready("fill_ready");
        wq.delete();
        for (int i = 0; i < 120; i++) send_char(8'h30 + 8'(i % 64));
        bad = 0;
        check_eq("fill_count", wq.size(), 120);
        if (wq.size() >= 120) begin
            for (int unsigned i = 0; i < 120; i++) begin
                if (wq[i].a != 11'(i) || wq[i].d != 8'h30 + 8'(i % 64)) bad++;
            end
        end
        check_eq("fill_bad", bad, 0);
        check_cursor("fill120", 4'd10, 4'd10);
        wq.delete();
        send_char(8'h7E);
        check_write("last_cell", 11'd120, 8'h7E);
        check_cursor("wrap", 4'd0, 4'd0);
        wait_ready("wrap_ready");
`ifdef CONSOLE_AUTOCLEAR_EN
        check_sweep("autoclr", 1);
`else
        check_eq("wrap_no_clear", wq.size(), 1);
`endif
        send_char(8'h21);
        check_write("char122", 11'd0, 8'h21);
        check_cursor("char122", 4'd1, 4'd0);

        // Reset in the middle of a sweep
        pulse_clear();
        n = 0;
        while (!(MemWrite === 1'b1 && DataAdr === 11'd50) && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        check_eq("sweep_at_50", {21'd0, DataAdr}, 32'd50);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_we",    {31'd0, MemWrite},       32'd0);
        check_eq("midrst_addr",  {21'd0, DataAdr},        32'd0);
        check_eq("midrst_data",  {24'd0, WriteData},      32'h20);
        check_eq("midrst_ready", {31'd0, cif.char_ready}, 32'd0);
        check_eq("midrst_busy",  {31'd0, busy},           32'd1);
        check_cursor("midrst", 4'd0, 4'd0);
        @(negedge clk); #1;
        wq.delete();
        rst_n = 1'b1;
        wait_ready("midrst_ready_after");
        check_sweep("midrst_sweep", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
